// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types for the shift_seq_ctrl serializer.
// State encoding is fixed at 2 bits so that the optional parity state
// (SHIFT_SEQ_PARITY_EN) does not change the state register width.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bit counter width: must hold the values 0 .. WIDTH.
  function automatic int bit_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Bus bundle for shift_seq_ctrl: producer handshake, per-frame
// configuration, serial outputs and a state debug tap.
// Handshake: a word transfers on a rising edge where in_valid && in_ready;
// the producer holds in_valid/in_data/lsb_first/clk_div stable until then
// and must not wait for in_ready before raising in_valid.
// Optional parity (SHIFT_SEQ_PARITY_EN) does not change this bundle.
interface shift_seq_ctrl_if
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             lsb_first;
  logic [DIV_W-1:0] clk_div;
  logic             ser_out;
  logic             ser_en;
  logic             bit_tick;
  logic             done;
  logic             busy;
  state_e           dbg_state;

  // Controller side
  modport slave (
    input  in_valid, in_data, lsb_first, clk_div,
    output in_ready, ser_out, ser_en, bit_tick, done, busy, dbg_state
  );

  // Producer / observer side
  modport master (
    output in_valid, in_data, lsb_first, clk_div,
    input  in_ready, ser_out, ser_en, bit_tick, done, busy, dbg_state
  );
endinterface

// File: rtl/shift_seq_ctrl_bit_timer.sv
// bit_timer: loadable down-counter that measures one bit period.
// tick is high while enabled and the count has reached zero; a load on
// the same cycle restarts the period. Unaffected by SHIFT_SEQ_PARITY_EN.
module bit_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Next count: load has priority, otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == '0);
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serializer controller. Accepts a parallel word over
// valid/ready, latches bit order and bit period, then shifts the word out
// one bit per (clk_div+1) cycles and pulses done after the last bit.
// Define SHIFT_SEQ_PARITY_EN to append one even-parity bit period.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic clk,
  input  logic rst,
  shift_seq_ctrl_if.slave bus
);
  localparam int CNT_W = bit_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SHIFT  = ST_SHIFT;
  localparam logic [1:0] S_DONE   = ST_DONE;
`ifdef SHIFT_SEQ_PARITY_EN
  localparam logic [1:0] S_PARITY = ST_PARITY;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lsb_q, lsb_d;
  logic [DIV_W-1:0] div_q, div_d;
`ifdef SHIFT_SEQ_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             timer_load;
  logic [DIV_W-1:0] timer_val;
  logic             timer_en;
  logic             tick;

  assign timer_en = (state_q == S_SHIFT)
`ifdef SHIFT_SEQ_PARITY_EN
                 || (state_q == S_PARITY)
`endif
                 ;

  bit_timer #(.DIV_W(DIV_W)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .tick     (tick)
  );

  // FSM, shift register and frame configuration next-state logic
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    lsb_d      = lsb_q;
    div_d      = div_q;
`ifdef SHIFT_SEQ_PARITY_EN
    par_d      = par_q;
`endif
    timer_load = 1'b0;
    timer_val  = div_q;
    case (state_q)
      S_IDLE: begin
        // in_ready is high in IDLE, so in_valid alone means a handshake
        if (bus.in_valid) begin
          sh_d       = bus.in_data;
          lsb_d      = bus.lsb_first;
          div_d      = bus.clk_div;
          cnt_d      = '0;
`ifdef SHIFT_SEQ_PARITY_EN
          par_d      = ^bus.in_data;
`endif
          timer_load = 1'b1;
          timer_val  = bus.clk_div;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (cnt_q != LAST_BIT) begin
            sh_d       = lsb_q ? (sh_q >> 1) : (sh_q << 1);
            cnt_d      = cnt_q + 1'b1;
            timer_load = 1'b1;
          end else begin
`ifdef SHIFT_SEQ_PARITY_EN
            timer_load = 1'b1;
            state_d    = S_PARITY;
`else
            state_d    = S_DONE;
`endif
          end
        end
      end
`ifdef SHIFT_SEQ_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      lsb_q   <= 1'b0;
      div_q   <= '0;
`ifdef SHIFT_SEQ_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      lsb_q   <= lsb_d;
      div_q   <= div_d;
`ifdef SHIFT_SEQ_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Serial data: current end of the shift register, or the parity bit
  always_comb begin
    bus.ser_out = 1'b0;
    if (state_q == S_SHIFT) begin
      bus.ser_out = lsb_q ? sh_q[0] : sh_q[WIDTH-1];
    end
`ifdef SHIFT_SEQ_PARITY_EN
    if (state_q == S_PARITY) begin
      bus.ser_out = par_q;
    end
`endif
  end

  assign bus.ser_en    = timer_en;
  assign bus.bit_tick  = tick;
  assign bus.done      = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.dbg_state = state_e'(state_q);
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Serializer controller that sequences a WIDTH-bit shift datapath.
- Accepts parallel words over a valid/ready handshake.
- Latches the per-frame configuration (bit order, bit period).
- Shifts the word out one bit per programmable bit period and signals frame completion.
- Sits between a parallel producer (CPU/FIFO) and a serial pin or serial consumer.

Parameters:
WIDTH, 8, data word width in bits (>= 2)
DIV_W, 8, width of bit-period divisor input

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  producer has a word on in_data
in_ready  output  1  controller can accept a word this cycle
in_data  input  WIDTH  parallel word to serialize
lsb_first  input  1  0 = MSB first, 1 = LSB first; sampled at handshake
clk_div  input  DIV_W  bit period = clk_div+1 clk cycles; sampled at handshake
ser_out  output  1  serial data bit
ser_en  output  1  high while a bit is being driven (frame active)
bit_tick  output  1  one-cycle pulse on the last cycle of each bit period
done  output  1  one-cycle pulse after the final bit period
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, any time including mid-frame):
  - State goes to IDLE.
  - ser_out=0, ser_en=0, bit_tick=0, done=0, busy=0.
  - Internal shift register, bit counter and divider counter clear to 0.
  - in_ready=1 once rst deasserts.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, busy=0, ser_out=0.
  - Handshake occurs when in_valid && in_ready on a rising edge. At that edge the controller:
    - latches in_data, lsb_first and clk_div;
    - loads the divider counter with clk_div and the bit counter with 0;
    - moves to SHIFT.
- SHIFT:
  - in_ready=0, busy=1, ser_en=1.
  - ser_out is register[WIDTH-1] when MSB first, register[0] when LSB first. The first bit appears in the cycle after the handshake.
  - The divider counts down. At count 0, bit_tick=1 and:
    - if the bit counter is below WIDTH-1: shift the register (left for MSB first, right for LSB first, zero fill), increment the bit counter, reload the divider with the latched clk_div;
    - if the bit counter equals WIDTH-1: go to DONE.
- DONE:
  - Lasts 1 cycle: done=1, ser_en=0, ser_out=0, in_ready=0, busy=1.
  - Next state is IDLE.
- Latency:
  - With handshake at cycle 0, bit k occupies cycles 1+k*(D+1) through (k+1)*(D+1), where D is the latched clk_div.
  - done is asserted at cycle WIDTH*(D+1)+1.
  - in_ready is high again at cycle WIDTH*(D+1)+2.
  - Back-to-back frames therefore have a minimum 2-cycle gap (DONE, then the IDLE handshake cycle).
- Boundary and edge cases:
  - clk_div=0: 1 cycle per bit, bit_tick high every SHIFT cycle.
  - clk_div=all-ones: 2^DIV_W cycles per bit, with no divider overflow.
  - Changes on in_data, lsb_first or clk_div during a frame are ignored.
  - in_valid held while busy: no handshake occurs. The producer must hold the word, and it is accepted on the first IDLE cycle.
  - in_valid must not be gated on in_ready.

Optional Feature:
- Macro: SHIFT_SEQ_PARITY_EN.
- When defined:
  - After the WIDTH data bits, one extra bit period drives the even-parity bit (XOR of the latched word).
  - ser_en stays 1 and bit_tick fires for the parity bit.
  - done moves to cycle (WIDTH+1)*(D+1)+1.
  - A PARITY state sits between SHIFT and DONE.
- When undefined: exactly WIDTH bits are sent, there is no PARITY state, and timing is as above.

Decomposition:
- Package shift_seq_pkg holds:
  - the state enum typedef (IDLE, SHIFT, PARITY, DONE), 2-bit encoding;
  - localparam helper for bit-counter width: $clog2(WIDTH+1).
- One sub-module, bit_timer:
  - loadable DIV_W down-counter;
  - inputs: load, load value, enable;
  - output: the tick (count==0 while enabled).
- Shift register, bit counter and FSM stay in shift_seq_ctrl.

Test Plan:
1. Reset then idle: rst pulse; in_valid=0 for 10 cycles -> in_ready=1, busy=0, ser_out=0, ser_en=0, no done.
2. MSB first, fast: WIDTH=8, in_data=8'hA5, lsb_first=0, clk_div=0 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1-8; done at cycle 9; in_ready high at cycle 10.
3. LSB first, divided: in_data=8'h81, lsb_first=1, clk_div=3 -> each bit held 4 cycles; sequence 1,0,0,0,0,0,0,1; 8 bit_ticks; done at cycle 33.
4. Back-to-back with config change: words 8'hF0 then 8'h0F, in_valid held high, lsb_first toggled mid-frame -> first frame unaffected; second handshake on the IDLE cycle after done; gap of 2 cycles.
5. Async reset mid-frame: assert rst at cycle 4 of a clk_div=0 frame -> outputs 0 immediately (same cycle, no clock edge needed); no done; next frame after reset serializes correctly.
6. Parity (SHIFT_SEQ_PARITY_EN): in_data=8'h07, clk_div=1 -> 8 data bits, then parity bit=1 for 2 cycles; done at cycle 19.
